boot_loader_ctrl: RTL and testbench



---
 rtl/boot_loader_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl
//   Reads an image packet out of the UART RX byte FIFO and loads its payload
//   into instruction memory as 32-bit words, starting at word address 0.
//   Packet layout: SYNC_BYTE, word count (LSB first), payload words (each
//   little-endian), then an 8-bit mod-256 checksum of the payload bytes.
//
// Ports
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         single-cycle pulse that arms the loader (ignored while busy)
//   fifo_empty    RX FIFO empty flag
//   fifo_rdata    RX FIFO data, valid when fifo_read is high
//   fifo_read     RX FIFO pop request (never high while fifo_empty)
//   mem_we        instruction-memory write strobe (one cycle per word)
//   mem_addr      word address, holds its value between writes
//   mem_wdata     word data, holds its value between writes
//   busy          high while a packet is being parsed
//   done          sticky: packet loaded and checksum matched
//   error         sticky: packet aborted
//   err_code      01 length too large, 10 checksum mismatch, 11 timeout
//   words_loaded  number of words written for the current packet
// -----------------------------------------------------------------------------
module boot_loader_ctrl #(
    parameter int unsigned MEM_ADDR_WIDTH = 14,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      fifo_empty,
    input  logic [7:0]                fifo_rdata,
    output logic                      fifo_read,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [15:0]               words_loaded
);

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);
    localparam logic [31:0] TmoLast  = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                    state_q, state_d;
    logic [15:0]               len_q, len_d;
    logic [1:0]                lane_q, lane_d;
    logic [23:0]               word_q, word_d;
    logic [7:0]                csum_q, csum_d;
    logic [15:0]               widx_q, widx_d;
    logic [31:0]               tmo_q, tmo_d;
    logic                      mem_we_q, mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]               mem_wdata_q, mem_wdata_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic [1:0]                err_code_q, err_code_d;

    logic        parsing;
    logic        timed;
    logic        pop;
    logic [15:0] len_full;

    assign parsing  = (state_q == S_SYNC) || (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);
    assign timed    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA) || (state_q == S_CHECK);
    assign pop      = parsing & ~fifo_empty;
    assign len_full = {fifo_rdata, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        lane_d      = lane_q;
        word_d      = word_q;
        csum_d      = csum_q;
        widx_d      = widx_q;
        tmo_d       = '0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d    = S_SYNC;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'b00;
                    widx_d     = '0;
                    csum_d     = '0;
                    lane_d     = '0;
                end
            end
            S_SYNC: begin
                if (pop && fifo_rdata == SYNC_BYTE) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (pop) begin
                    len_d[7:0] = fifo_rdata;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (pop) begin
                    len_d[15:8] = fifo_rdata;
                    if ({1'b0, len_full} > MaxWords) begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (pop) begin
                    csum_d = csum_q + fifo_rdata;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        // lanes 0..2 were shifted in from the top, so they sit in
                        // little-endian order below the final byte
                        mem_we_d    = 1'b1;
                        mem_addr_d  = MEM_ADDR_WIDTH'(widx_q);
                        mem_wdata_d = {fifo_rdata, word_q};
                        widx_d      = widx_q + 16'd1;
                        if (widx_q + 16'd1 == len_q) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        word_d = {fifo_rdata, word_q[23:8]};
                    end
                end
            end
            S_CHECK: begin
                if (pop) begin
                    if (fifo_rdata == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        err_code_d = 2'b10;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counter runs only on empty cycles of the post-sync states; any
        // consumed byte or any other state leaves it cleared.
        if (timed && fifo_empty) begin
            if (tmo_q == TmoLast) begin
                state_d    = S_ERROR;
                error_d    = 1'b1;
                err_code_d = 2'b11;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            lane_q      <= '0;
            word_q      <= '0;
            csum_q      <= '0;
            widx_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            widx_q      <= widx_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign fifo_read    = pop;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = parsing;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign words_loaded = widx_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_loader_ctrl
//   Self-checking bench for boot_loader_ctrl: a queue-backed RX FIFO with
//   optional random empty gaps, a packet-level reference model, and a write
//   scoreboard fed from the model.
// -----------------------------------------------------------------------------
module tb_boot_loader_ctrl;

    localparam int AW   = 2;
    localparam int MAXW = 4;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [7:0]    fifo_rdata = 8'h00;
    logic          fifo_read;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [15:0]   words_loaded;

    boot_loader_ctrl #(
        .MEM_ADDR_WIDTH (AW),
        .MAX_WORDS      (MAXW),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .fifo_rdata   (fifo_rdata),
        .fifo_read    (fifo_read),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0] fq[$];
    logic [7:0] pkt[$];
    wr_t        exp_wr[$];
    bit         gaps_en = 1'b0;
    int         run = 0;
    int         pops = 0;
    int         rd_empty_cnt = 0;
    int         wr_seen = 0;

    int e_done, e_err, e_code, e_words, e_consumed;

    // FIFO model and write monitor: inputs change on the falling edge, the pop
    // decision is taken just before the rising edge the DUT samples on.
    always @(negedge clk) begin
        wr_t w;
        if (mem_we) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                w = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), w.addr);
                check("wr_data", mem_wdata, w.data);
            end
        end
        if (fq.size() == 0)
            fifo_empty = 1'b1;
        else if (gaps_en && run < 8 && $urandom_range(0, 2) == 0)
            fifo_empty = 1'b1;
        else
            fifo_empty = 1'b0;
        run = fifo_empty ? run + 1 : 0;
        fifo_rdata = fifo_empty ? 8'($urandom) : fq[0];
        #4;
        if (fifo_read && fifo_empty) rd_empty_cnt++;
        if (fifo_read && !fifo_empty) begin
            void'(fq.pop_front());
            pops++;
        end
    end

    // Packet-level reference: scan for sync, read length, build words, compare sum.
    task automatic model_pkt();
        int i;
        int len;
        int sum;
        logic [31:0] word;
        exp_wr.delete();
        e_done = 0; e_err = 0; e_code = 0; e_words = 0;
        i = 0;
        while (i < pkt.size() && pkt[i] != 8'hA5) i++;
        i++;
        len = int'(pkt[i]) + 256 * int'(pkt[i+1]);
        i += 2;
        if (len > MAXW) begin
            e_err = 1; e_code = 1; e_consumed = i;
            return;
        end
        sum = 0;
        for (int w = 0; w < len; w++) begin
            word = 32'(pkt[i]) + 32'(pkt[i+1]) * 256 + 32'(pkt[i+2]) * 65536 + 32'(pkt[i+3]) * 16777216;
            sum  = sum + pkt[i] + pkt[i+1] + pkt[i+2] + pkt[i+3];
            exp_wr.push_back('{addr: 32'(w), data: word});
            i += 4;
        end
        e_words = len;
        if (int'(pkt[i]) == sum % 256) e_done = 1;
        else begin e_err = 1; e_code = 2; end
        e_consumed = i + 1;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_pkt(input bit gaps, input bit mid_start);
        bit finished;
        model_pkt();
        pops = 0; rd_empty_cnt = 0; wr_seen = 0;
        gaps_en = gaps;
        foreach (pkt[k]) fq.push_back(pkt[k]);
        fq.push_back(8'h5A);
        pulse_start();
        if (mid_start) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        finished = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (done || error) begin finished = 1'b1; break; end
            @(negedge clk);
        end
        if (!finished) check("finish_wait", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        check("done",          32'(done),         32'(e_done));
        check("error",         32'(error),        32'(e_err));
        check("err_code",      32'(err_code),     32'(e_code));
        check("words_loaded",  32'(words_loaded), 32'(e_words));
        check("write_count",   32'(wr_seen),      32'(e_words));
        check("busy_after",    32'(busy),         32'd0);
        check("writes_left",   32'(exp_wr.size()), 32'd0);
        check("bytes_consumed", 32'(pops),        32'(e_consumed));
        check("sentinel_kept", 32'(fq.size()),    32'd1);
        check("rd_while_empty", 32'(rd_empty_cnt), 32'd0);
        check("done_and_error", 32'(done & error), 32'd0);
        fq.delete();
        exp_wr.delete();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_fifo_read"},    32'(fifo_read),    32'd0);
        check({pfx, "_mem_we"},       32'(mem_we),       32'd0);
        check({pfx, "_mem_addr"},     32'(mem_addr),     32'd0);
        check({pfx, "_mem_wdata"},    mem_wdata,         32'd0);
        check({pfx, "_busy"},         32'(busy),         32'd0);
        check({pfx, "_done"},         32'(done),         32'd0);
        check({pfx, "_error"},        32'(error),        32'd0);
        check({pfx, "_err_code"},     32'(err_code),     32'd0);
        check({pfx, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic rand_pkt();
        int g, sel, len, sum;
        logic [7:0] b;
        pkt.delete();
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
            b = 8'($urandom);
            pkt.push_back(b == 8'hA5 ? 8'h00 : b);
        end
        sel = $urandom_range(0, 6);
        len = (sel < 6) ? sel : 16'h0102;
        pkt.push_back(8'hA5);
        pkt.push_back(8'(len % 256));
        pkt.push_back(8'(len / 256));
        if (len <= MAXW) begin
            sum = 0;
            for (int k = 0; k < 4 * len; k++) begin
                b = 8'($urandom);
                sum += b;
                pkt.push_back(b);
            end
            if ($urandom_range(0, 3) == 0) sum += $urandom_range(1, 255);
            pkt.push_back(8'(sum % 256));
        end
    endtask

    initial begin
        bit ok;

        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // nominal single-word load
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        run_pkt(1'b0, 1'b0);

        // sync hunt with FIFO gaps, plus a start pulse while busy
        pkt = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
        run_pkt(1'b1, 1'b1);

        // bad checksum
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        run_pkt(1'b0, 1'b0);

        // oversize length
        pkt = '{8'hA5, 8'h05, 8'h00};
        run_pkt(1'b0, 1'b0);

        // zero-length packet
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_pkt(1'b1, 1'b0);

        // timeout: last byte consumed, then TMO empty cycles
        pops = 0; wr_seen = 0; rd_empty_cnt = 0;
        gaps_en = 1'b1;
        fq = '{8'hA5, 8'h01, 8'h00, 8'h11};
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (fq.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("tmo_drain_wait", 32'd0, 32'd1);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_early", 32'(error), 32'd0);
        @(negedge clk);
        check("tmo_error",    32'(error),        32'd1);
        check("tmo_err_code", 32'(err_code),     32'd3);
        check("tmo_done",     32'(done),         32'd0);
        check("tmo_busy",     32'(busy),         32'd0);
        check("tmo_words",    32'(words_loaded), 32'd0);
        check("tmo_rd_empty", 32'(rd_empty_cnt), 32'd0);

        // restart after timeout
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        run_pkt(1'b0, 1'b0);

        // reset in the middle of DATA
        pops = 0; wr_seen = 0;
        gaps_en = 1'b0;
        fq = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (pops >= 5) begin ok = 1'b1; break; end
        end
        if (!ok) check("rst_mid_wait", 32'd0, 32'd1);
        rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_writes", 32'(wr_seen), 32'd0);
        check("rst_no_reads",  32'(pops),    32'd5);
        check("rst_idle",      32'(busy),    32'd0);
        fq.delete();

        // randomized packets
        for (int n = 0; n < 25; n++) begin
            rand_pkt();
            run_pkt(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
